// File: rtl/data_memory_lsu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// data_memory_lsu
//
// Purpose:
//   Load/store unit in front of a word-organised data RAM. It handles MIPS
//   byte, halfword and word accesses (LB/LBU/LH/LHU/LW/SB/SH/SW). Addressing
//   is little-endian. Requests use a valid/ready handshake. The response
//   arrives WAIT_STATES cycles after acceptance and is flagged with an error
//   when the access is misaligned, out of range or of illegal size.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   WAIT_STATES  extra cycles between acceptance and response (0..15)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset (RAM contents are kept)
//   req_valid     request present
//   req_ready     block can accept a request this cycle
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads only: zero-extend when 1, sign-extend when 0
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   resp_valid    one-cycle response pulse
//   resp_rdata    extended load data (0 for stores and errors), held
//   resp_err      request was misaligned, out of range or illegal, held
// -----------------------------------------------------------------------------
module data_memory_lsu #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam int         WAIT_M1   = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
    localparam logic [3:0] WAIT_LOAD = WAIT_M1[3:0];
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Merge right-aligned store data into the addressed lane(s) of a word.
    function automatic logic [31:0] merge_store(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] res;
        res = old_word;
        case (size)
            SZ_BYTE: res[{lane, 3'b000} +: 8]      = wdata[7:0];
            SZ_HALF: res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            SZ_WORD: res                           = wdata;
            default: res                           = old_word;
        endcase
        return res;
    endfunction

    // Pick the addressed lane(s) out of a word and extend to 32 bits.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic [31:0] res;
        logic [7:0]  b;
        logic [15:0] h;
        res = 32'd0;
        b   = word[{lane, 3'b000} +: 8];
        h   = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: res = {{24{b[7] & ~uns}}, b};
            SZ_HALF: res = {{16{h[15] & ~uns}}, h};
            SZ_WORD: res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Data array. Reset never touches it.
    logic [31:0] r_mem [DEPTH_WORDS];

    state_t      r_state;
    logic        r_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic [3:0]  r_wait_cnt;

    // Request captured at acceptance, used when the commit happens later.
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_err;

    logic          w_misalign;
    logic          w_range_err;
    logic          w_req_err;
    logic          w_accept;
    logic          w_enter_resp;
    logic          w_cmd_we;
    logic [1:0]    w_cmd_size;
    logic          w_cmd_unsigned;
    logic [AW+1:0] w_cmd_addr;
    logic [31:0]   w_cmd_wdata;
    logic          w_cmd_err;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic [31:0]   w_old_word;
    logic [31:0]   w_resp_data;

    // Alignment and size legality of the incoming request.
    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = req_addr[0];
            SZ_WORD: w_misalign = (req_addr[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end

    // Any address bit beyond the array is an error; addresses never wrap.
    assign w_range_err = ((req_addr >> (AW + 2)) != 32'd0);
    assign w_req_err   = w_misalign | w_range_err;
    assign w_accept    = req_valid & r_ready;

    // The commit edge is the one entering RESP: the acceptance edge itself
    // when there are no wait states, otherwise the end of the BUSY count.
    assign w_enter_resp = ((r_state == ST_IDLE) && w_accept && NO_WAIT) ||
                          ((r_state == ST_BUSY) && (r_wait_cnt == 4'd0));

    // In IDLE the commit (zero-wait case) uses the live request; later it
    // uses the copy captured at acceptance.
    always_comb begin
        w_cmd_we       = r_we;
        w_cmd_size     = r_size;
        w_cmd_unsigned = r_unsigned;
        w_cmd_addr     = r_addr;
        w_cmd_wdata    = r_wdata;
        w_cmd_err      = r_err;
        if (r_state == ST_IDLE) begin
            w_cmd_we       = req_we;
            w_cmd_size     = req_size;
            w_cmd_unsigned = req_unsigned;
            w_cmd_addr     = req_addr[AW+1:0];
            w_cmd_wdata    = req_wdata;
            w_cmd_err      = w_req_err;
        end else begin
            w_cmd_we       = r_we;
            w_cmd_size     = r_size;
            w_cmd_unsigned = r_unsigned;
            w_cmd_addr     = r_addr;
            w_cmd_wdata    = r_wdata;
            w_cmd_err      = r_err;
        end
    end

    assign w_idx      = w_cmd_addr[AW+1:2];
    assign w_lane     = w_cmd_addr[1:0];
    assign w_old_word = r_mem[w_idx];

    // Response data: stores and errors report zero.
    always_comb begin
        w_resp_data = 32'd0;
        if (w_cmd_err || w_cmd_we) begin
            w_resp_data = 32'd0;
        end else begin
            w_resp_data = load_extract(w_old_word, w_cmd_size, w_lane, w_cmd_unsigned);
        end
    end

    // RAM write port: read-modify-write of the addressed word on commit.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && w_cmd_we && !w_cmd_err) begin
            r_mem[w_idx] <= merge_store(w_old_word, w_cmd_wdata, w_cmd_size, w_lane);
        end
    end

    // Handshake FSM with registered ready/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_wait_cnt   <= 4'd0;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr[AW+1:0];
                        r_wdata    <= req_wdata;
                        r_err      <= w_req_err;
                        r_ready    <= 1'b0;
                        if (NO_WAIT) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_resp_data;
                            r_resp_err   <= w_cmd_err;
                        end else begin
                            r_state    <= ST_BUSY;
                            r_wait_cnt <= WAIT_LOAD;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    r_ready <= 1'b0;
                    if (r_wait_cnt == 4'd0) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_resp_data;
                        r_resp_err   <= w_cmd_err;
                    end else begin
                        r_state    <= ST_BUSY;
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_wait_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_memory_lsu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_data_memory_lsu
//
// Two instances: index 0 has DEPTH_WORDS=16, WAIT_STATES=0; index 1 has
// DEPTH_WORDS=64, WAIT_STATES=3. A byte-array reference model computes load
// results and error flags from the access rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_data_memory_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        resp_valid   [2];
    logic [31:0] resp_rdata   [2];
    logic        resp_err     [2];

    data_memory_lsu #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_memory_lsu #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference memory, byte granular, one per instance.
    logic [7:0] mm [2][256];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Reference behaviour of one access; updates the model on legal stores.
    task automatic model_op(input int d, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wdata,
                            output logic [31:0] er, output logic ee);
        int unsigned limit;
        int unsigned nbytes;
        logic [31:0] v;
        limit  = (d == 0) ? 64 : 256;
        nbytes = 1 << size;
        ee = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
             (size == 2'd2 && (addr % 4) != 0) || (addr >= limit);
        er = 32'd0;
        if (!ee) begin
            if (we) begin
                for (int k = 0; k < int'(nbytes); k++)
                    mm[d][addr[7:0] + 8'(k)] = wdata[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < int'(nbytes); k++)
                    v = v | ({24'd0, mm[d][addr[7:0] + 8'(k)]} << (8 * k));
                if (nbytes < 4 && !uns && v[8*nbytes-1])
                    v = v - (32'd1 << (8 * nbytes));
                er = v;
            end
        end
    endtask

    // One complete request/response, checked against the model.
    task automatic xact(input int d, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag,
                        output logic [31:0] got, output logic got_err);
        logic [31:0] er;
        logic        ee;
        int          cyc;
        model_op(d, we, size, uns, addr, wdata, er, ee);
        @(posedge clk); #1;
        check_eq({tag, "_ready"}, {31'd0, req_ready[d]}, 32'd1);
        req_we[d]       = we;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        req_valid[d]    = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        cyc = 0;
        while (!resp_valid[d] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, "_lat"}, 32'(cyc), 32'(wait_of(d)));
        got     = resp_rdata[d];
        got_err = resp_err[d];
        check_eq({tag, "_rdata"}, resp_rdata[d], er);
        check_eq({tag, "_err"}, {31'd0, resp_err[d]}, {31'd0, ee});
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, {31'd0, resp_valid[d]}, 32'd0);
        check_eq({tag, "_hold"}, resp_rdata[d], er);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic        ge;
        int          nresp;
        logic        saw;

        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 256; b++) mm[d][b] = 8'd0;
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
            req_unsigned[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_ready", {31'd0, req_ready[d]}, 32'd1);
            check_eq("rst_valid", {31'd0, resp_valid[d]}, 32'd0);
            check_eq("rst_rdata", resp_rdata[d], 32'd0);
            check_eq("rst_err", {31'd0, resp_err[d]}, 32'd0);
        end
        rst = 1'b0;

        // Bring both arrays to a known all-zero image.
        for (int w = 0; w < 16; w++) xact(0, 1'b1, 2'd2, 1'b0, 32'(w * 4), 32'd0, "fill0", got, ge);
        for (int w = 0; w < 64; w++) xact(1, 1'b1, 2'd2, 1'b0, 32'(w * 4), 32'd0, "fill1", got, ge);

        // Word store/load round trip
        xact(0, 1'b1, 2'd2, 1'b0, 32'h0, 32'hA5A5A5A5, "t1_sw", got, ge);
        xact(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "t1_lw", got, ge);
        check_eq("t1_lw_const", got, 32'hA5A5A5A5);

        // Sub-word loads with extension
        xact(0, 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, "t2_sw", got, ge);
        xact(0, 1'b0, 2'd0, 1'b0, 32'h8, 32'h0, "t2_lb", got, ge);
        check_eq("t2_lb_const", got, 32'hFFFFFFEF);
        xact(0, 1'b0, 2'd0, 1'b1, 32'hB, 32'h0, "t2_lbu", got, ge);
        check_eq("t2_lbu_const", got, 32'h000000DE);
        xact(0, 1'b0, 2'd1, 1'b0, 32'hA, 32'h0, "t2_lh", got, ge);
        check_eq("t2_lh_const", got, 32'hFFFFDEAD);
        xact(0, 1'b0, 2'd1, 1'b1, 32'h8, 32'h0, "t2_lhu", got, ge);
        check_eq("t2_lhu_const", got, 32'h0000BEEF);

        // Sub-word stores preserve other lanes
        xact(0, 1'b1, 2'd0, 1'b0, 32'h9, 32'hFFFFFF12, "t3_sb", got, ge);
        xact(0, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, "t3_lw1", got, ge);
        check_eq("t3_lw1_const", got, 32'hDEAD12EF);
        xact(0, 1'b1, 2'd1, 1'b0, 32'hA, 32'hABCD5678, "t3_sh", got, ge);
        xact(0, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, "t3_lw2", got, ge);
        check_eq("t3_lw2_const", got, 32'h567812EF);

        // Error cases
        xact(0, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, "t4_lw_mis", got, ge);
        check_eq("t4_lw_mis_e", {31'd0, ge}, 32'd1);
        xact(0, 1'b0, 2'd1, 1'b0, 32'h3, 32'h0, "t4_lh_mis", got, ge);
        check_eq("t4_lh_mis_e", {31'd0, ge}, 32'd1);
        xact(0, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, "t4_size3", got, ge);
        check_eq("t4_size3_e", {31'd0, ge}, 32'd1);
        xact(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hFFFFFFFF, "t4_sw_oor", got, ge);
        check_eq("t4_sw_oor_e", {31'd0, ge}, 32'd1);
        xact(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "t4_lw0", got, ge);
        check_eq("t4_lw0_const", got, 32'hA5A5A5A5);
        xact(0, 1'b1, 2'd2, 1'b0, 32'h3C, 32'h13572468, "t4_sw_last", got, ge);
        xact(0, 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, "t4_lw_last", got, ge);

        // Held req_valid with wait states: one accept every 5 cycles
        @(posedge clk); #1;
        req_we[1] = 1'b0; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
        req_addr[1] = 32'h0; req_valid[1] = 1'b1;
        nresp = 0;
        for (int j = 0; j < 15; j++) begin
            @(posedge clk); #1;
            check_eq("t5_ready", {31'd0, req_ready[1]}, {31'd0, (j % 5) == 4});
            check_eq("t5_valid", {31'd0, resp_valid[1]}, {31'd0, (j % 5) == 3});
            if (resp_valid[1]) nresp++;
        end
        req_valid[1] = 1'b0;
        check_eq("t5_nresp", 32'(nresp), 32'd3);

        // Reset while BUSY drops the pending store
        xact(1, 1'b1, 2'd2, 1'b0, 32'h4, 32'h5A5A5A5A, "t6_sw", got, ge);
        @(posedge clk); #1;
        req_we[1] = 1'b1; req_size[1] = 2'd2; req_addr[1] = 32'h4;
        req_wdata[1] = 32'h11111111; req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check_eq("t6_busy", {31'd0, req_ready[1]}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t6_ready", {31'd0, req_ready[1]}, 32'd1);
        saw = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (resp_valid[1]) saw = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("t6_no_resp", {31'd0, saw}, 32'd0);
        xact(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "t6_lw", got, ge);
        check_eq("t6_lw_const", got, 32'h5A5A5A5A);

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            int          d;
            int unsigned lim;
            logic [1:0]  sz;
            logic [31:0] a;
            d   = int'($urandom_range(0, 1));
            lim = (d == 0) ? 64 : 256;
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) a = $urandom();
            else a = $urandom_range(0, lim - 1);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            xact(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                 a, $urandom(), "rnd", got, ge);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
